// File: rtl/lsu_misalign_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings, FSM state
// enum and access-size / legality / alignment helpers.
package lsu_misalign_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPLIT = 2'd1,
        DONE  = 2'd2
    } lsu_state_e;

    // Bytes touched by the access; funct3[1:0] carries the size for both loads and stores.
    function automatic logic [2:0] access_size(input logic [2:0] fun3);
        logic [2:0] size;
        case (fun3[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;
        endcase
        return size;
    endfunction

    function automatic logic is_legal_load(input logic [2:0] fun3);
        return (fun3 == LB) || (fun3 == LH) || (fun3 == LW) ||
               (fun3 == LBU) || (fun3 == LHU);
    endfunction

    function automatic logic is_legal_store(input logic [2:0] fun3);
        return (fun3 == SB) || (fun3 == SH) || (fun3 == SW);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] fun3, input logic [1:0] addr_lo);
        logic mis;
        case (access_size(fun3))
            3'd2:    mis = addr_lo[0];
            3'd4:    mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_misalign_load_ext.sv
// Turns the byte accumulator of a split load into the architectural result by
// sign- or zero-extending according to funct3.
module lsu_misalign_load_ext
    import lsu_misalign_pkg::*;
#(
    parameter int BIT_WIDTH = 32
) (
    input  logic [BIT_WIDTH-1:0] i_acc,
    input  logic [2:0]           i_fun3,
    output logic [BIT_WIDTH-1:0] o_data
);

    always_comb begin
        o_data = i_acc;
        case (i_fun3)
            LB:      o_data = {{(BIT_WIDTH-8){i_acc[7]}}, i_acc[7:0]};
            LBU:     o_data = {{(BIT_WIDTH-8){1'b0}}, i_acc[7:0]};
            LH:      o_data = {{(BIT_WIDTH-16){i_acc[15]}}, i_acc[15:0]};
            LHU:     o_data = {{(BIT_WIDTH-16){1'b0}}, i_acc[15:0]};
            default: o_data = i_acc;
        endcase
    end

endmodule

// File: rtl/lsu_misalign.sv
// Load/store unit between execute and data memory: aligned accesses pass through
// combinationally, misaligned halfword/word accesses are split into bytes or trapped.
module lsu_misalign
    import lsu_misalign_pkg::*;
#(
    parameter int BIT_WIDTH     = 32,
    parameter int MISALIGN_TRAP = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load,
    input  logic                 i_store,
    input  logic [2:0]           i_fun3,
    input  logic [BIT_WIDTH-1:0] i_addr,
    input  logic [BIT_WIDTH-1:0] i_wr_data,
    output logic                 o_stall,
    output logic                 o_done,
    output logic [BIT_WIDTH-1:0] o_rd_data,
    output logic                 o_misaligned,
    output logic                 o_illegal,
    output logic                 o_mem_rd_en,
    output logic                 o_mem_wr_en,
    output logic [2:0]           o_mem_fun3,
    output logic [BIT_WIDTH-1:0] o_mem_addr,
    output logic [BIT_WIDTH-1:0] o_mem_wr_data,
    input  logic [BIT_WIDTH-1:0] i_mem_rd_data
);

    localparam logic TRAP_EN = (MISALIGN_TRAP != 0);

    lsu_state_e           r_state;
    lsu_state_e           w_next_state;
    logic [1:0]           r_cnt;
    logic [BIT_WIDTH-1:0] r_acc;
    logic [BIT_WIDTH-1:0] r_addr;
    logic [BIT_WIDTH-1:0] r_wr_data;
    logic [2:0]           r_fun3;
    logic                 r_is_load;

    logic                 w_req;
    logic                 w_illegal;
    logic                 w_misaligned;
    logic                 w_start_split;
    logic [2:0]           w_last_idx;
    logic                 w_last;
    logic [4:0]           w_byte_lsb;
    logic [BIT_WIDTH-1:0] w_split_addr;
    logic [BIT_WIDTH-1:0] w_ext_data;

    assign w_req         = i_load | i_store;
    assign w_illegal     = (i_load & i_store)
                         | (i_load  & ~is_legal_load(i_fun3))
                         | (i_store & ~is_legal_store(i_fun3));
    assign w_misaligned  = is_misaligned(i_fun3, i_addr[1:0]);
    assign w_start_split = (r_state == IDLE) & w_req & ~w_illegal & w_misaligned & ~TRAP_EN;

    // The split runs from the latched request only, so the stalled inputs may wander freely.
    assign w_last_idx    = access_size(r_fun3) - 3'd1;
    assign w_last        = ({1'b0, r_cnt} == w_last_idx);
    assign w_byte_lsb    = {r_cnt, 3'b000};
    assign w_split_addr  = r_addr + {{(BIT_WIDTH-2){1'b0}}, r_cnt};

    lsu_misalign_load_ext #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_load_ext (
        .i_acc  (r_acc),
        .i_fun3 (r_fun3),
        .o_data (w_ext_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_split) w_next_state = SPLIT;
            SPLIT:   if (w_last)        w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= 2'd0;
            r_acc     <= '0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_fun3    <= 3'b000;
            r_is_load <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_split) begin
                        r_addr    <= i_addr;
                        r_fun3    <= i_fun3;
                        r_wr_data <= i_wr_data;
                        r_is_load <= i_load;
                        r_cnt     <= 2'd1;
                        r_acc     <= i_load ? {{(BIT_WIDTH-8){1'b0}}, i_mem_rd_data[7:0]} : '0;
                    end
                end
                SPLIT: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (r_is_load) begin
                        r_acc[w_byte_lsb +: 8] <= i_mem_rd_data[7:0];
                    end
                end
                DONE: begin
                    r_cnt <= 2'd0;
                end
                default: begin
                    r_cnt <= 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        o_stall       = 1'b0;
        o_done        = 1'b0;
        o_rd_data     = '0;
        o_misaligned  = 1'b0;
        o_illegal     = 1'b0;
        o_mem_rd_en   = 1'b0;
        o_mem_wr_en   = 1'b0;
        o_mem_fun3    = 3'b000;
        o_mem_addr    = '0;
        o_mem_wr_data = '0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_illegal) begin
                        o_illegal = 1'b1;
                        o_done    = 1'b1;
                    end else if (!w_misaligned) begin
                        o_mem_rd_en   = i_load;
                        o_mem_wr_en   = i_store;
                        o_mem_fun3    = i_fun3;
                        o_mem_addr    = i_addr;
                        o_mem_wr_data = i_wr_data;
                        o_done        = 1'b1;
                        o_rd_data     = i_load ? i_mem_rd_data : '0;
                    end else if (TRAP_EN) begin
                        o_misaligned = 1'b1;
                    end else begin
                        // Byte 0 goes out in the accepting cycle, so the split costs N issue cycles.
                        o_mem_rd_en   = i_load;
                        o_mem_wr_en   = i_store;
                        o_mem_fun3    = i_load ? LBU : SB;
                        o_mem_addr    = i_addr;
                        o_mem_wr_data = {{(BIT_WIDTH-8){1'b0}}, i_wr_data[7:0]};
                        o_stall       = 1'b1;
                    end
                end
            end
            SPLIT: begin
                o_mem_rd_en   = r_is_load;
                o_mem_wr_en   = ~r_is_load;
                o_mem_fun3    = r_is_load ? LBU : SB;
                o_mem_addr    = w_split_addr;
                o_mem_wr_data = {{(BIT_WIDTH-8){1'b0}}, r_wr_data[w_byte_lsb +: 8]};
                o_stall       = 1'b1;
            end
            DONE: begin
                o_done    = 1'b1;
                o_rd_data = r_is_load ? w_ext_data : '0;
            end
            default: begin
                o_done = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_misalign.sv
// Bench for lsu_misalign: a byte-array data memory, a byte-level reference model of
// loads/stores, directed scenarios and randomized traffic.
module tb_lsu_misalign;
    import lsu_misalign_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        tb_load;
    logic        tb_store;
    logic [2:0]  tb_fun3;
    logic [31:0] tb_addr;
    logic [31:0] tb_wr_data;
    logic [31:0] mem_rd_data;

    logic        w_stall, w_done, w_misaligned, w_illegal, w_mem_rd_en, w_mem_wr_en;
    logic [2:0]  w_mem_fun3;
    logic [31:0] w_rd_data, w_mem_addr, w_mem_wr_data;

    logic        t_stall, t_done, t_misaligned, t_illegal, t_mem_rd_en, t_mem_wr_en;
    logic [2:0]  t_mem_fun3;
    logic [31:0] t_rd_data, t_mem_addr, t_mem_wr_data;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem      [0:255];
    logic [7:0]  init_mem [0:255];
    logic [7:0]  exp_mem  [0:255];
    logic        mem_load;
    logic [7:0]  ma0, ma1, ma2, ma3;

    logic [31:0] exp_q[$];
    logic [31:0] obs_addr_q[$];
    logic [31:0] obs_wd_q[$];
    logic [2:0]  obs_f3_q[$];
    logic        obs_done, obs_stall_ok, obs_mis;
    logic [31:0] obs_rd;
    int          obs_cycles;

    lsu_misalign #(.BIT_WIDTH(32), .MISALIGN_TRAP(0)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_load(tb_load), .i_store(tb_store),
        .i_fun3(tb_fun3), .i_addr(tb_addr), .i_wr_data(tb_wr_data),
        .o_stall(w_stall), .o_done(w_done), .o_rd_data(w_rd_data),
        .o_misaligned(w_misaligned), .o_illegal(w_illegal),
        .o_mem_rd_en(w_mem_rd_en), .o_mem_wr_en(w_mem_wr_en), .o_mem_fun3(w_mem_fun3),
        .o_mem_addr(w_mem_addr), .o_mem_wr_data(w_mem_wr_data), .i_mem_rd_data(mem_rd_data)
    );

    lsu_misalign #(.BIT_WIDTH(32), .MISALIGN_TRAP(1)) u_trap (
        .i_clk(clk), .i_rst_n(rst_n), .i_load(tb_load), .i_store(tb_store),
        .i_fun3(tb_fun3), .i_addr(tb_addr), .i_wr_data(tb_wr_data),
        .o_stall(t_stall), .o_done(t_done), .o_rd_data(t_rd_data),
        .o_misaligned(t_misaligned), .o_illegal(t_illegal),
        .o_mem_rd_en(t_mem_rd_en), .o_mem_wr_en(t_mem_wr_en), .o_mem_fun3(t_mem_fun3),
        .o_mem_addr(t_mem_addr), .o_mem_wr_data(t_mem_wr_data), .i_mem_rd_data(mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational extended read, byte-lane write on the clock edge.
    assign ma0 = w_mem_addr[7:0];
    assign ma1 = ma0 + 8'd1;
    assign ma2 = ma0 + 8'd2;
    assign ma3 = ma0 + 8'd3;

    always_comb begin
        mem_rd_data = 32'h0;
        case (w_mem_fun3)
            3'b000:  mem_rd_data = {{24{mem[ma0][7]}}, mem[ma0]};
            3'b001:  mem_rd_data = {{16{mem[ma1][7]}}, mem[ma1], mem[ma0]};
            3'b010:  mem_rd_data = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
            3'b100:  mem_rd_data = {24'h0, mem[ma0]};
            3'b101:  mem_rd_data = {16'h0, mem[ma1], mem[ma0]};
            default: mem_rd_data = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_load) begin
            for (int k = 0; k < 256; k++) mem[k] <= init_mem[k];
        end else if (w_mem_wr_en) begin
            mem[ma0] <= w_mem_wr_data[7:0];
            if (w_mem_fun3[1:0] != 2'b00) mem[ma1] <= w_mem_wr_data[15:8];
            if (w_mem_fun3[1:0] == 2'b10) begin
                mem[ma2] <= w_mem_wr_data[23:16];
                mem[ma3] <= w_mem_wr_data[31:24];
            end
        end
    end

    // Reference model: byte-addressed memory image and access rules.
    function automatic int tb_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit tb_is_mis(input logic [2:0] f3, input logic [31:0] a);
        int n = tb_size(f3);
        return (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    endfunction

    function automatic int model_cycles(input logic [2:0] f3, input logic [31:0] a);
        return tb_is_mis(f3, a) ? tb_size(f3) + 1 : 1;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v = 32'h0;
        for (int k = 0; k < tb_size(f3); k++) begin
            logic [31:0] ak;
            ak = a + k;
            v = v | (32'(exp_mem[ak[7:0]]) << (8 * k));
        end
        if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    function automatic void model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        for (int k = 0; k < tb_size(f3); k++) begin
            logic [31:0] ak;
            ak = a + k;
            exp_mem[ak[7:0]] = wd[8*k +: 8];
        end
    endfunction

    // Expected memory-side traffic: one full access if aligned, else N byte accesses.
    function automatic bit seq_ok(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n = tb_size(f3);
        bit ok = 1'b1;
        if (!tb_is_mis(f3, a)) begin
            if (obs_addr_q.size() != 1) return 1'b0;
            ok = (obs_addr_q[0] == a) && (obs_f3_q[0] == f3) && (!st || obs_wd_q[0] == wd);
        end else begin
            if (obs_addr_q.size() != n) return 1'b0;
            for (int k = 0; k < n; k++) begin
                if (obs_addr_q[k] != a + k) ok = 1'b0;
                if (obs_f3_q[k] != (st ? 3'b000 : 3'b100)) ok = 1'b0;
                if (st && obs_wd_q[k][7:0] != wd[8*k +: 8]) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Driver: holds the request as a stalled pipeline would, records memory traffic until done.
    task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input bit scramble);
        obs_addr_q.delete();
        obs_wd_q.delete();
        obs_f3_q.delete();
        obs_done = 1'b0; obs_stall_ok = 1'b1; obs_mis = 1'b0; obs_cycles = 0; obs_rd = 32'h0;
        tb_load = ld; tb_store = st; tb_fun3 = f3; tb_addr = a; tb_wr_data = wd;
        for (int c = 0; c < 12; c++) begin
            #1;
            obs_cycles++;
            obs_mis = obs_mis | w_misaligned;
            if (w_mem_rd_en || w_mem_wr_en) begin
                obs_addr_q.push_back(w_mem_addr);
                obs_wd_q.push_back(w_mem_wr_data);
                obs_f3_q.push_back(w_mem_fun3);
            end
            if (w_done) begin
                obs_done = 1'b1;
                obs_rd   = w_rd_data;
                if (w_stall) obs_stall_ok = 1'b0;
                break;
            end
            if (!w_stall) break;
            @(negedge clk);
            if (scramble) begin
                tb_addr    = $urandom;
                tb_wr_data = $urandom;
            end
        end
        @(negedge clk);
        tb_load = 1'b0; tb_store = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (w_stall !== 1'b0 || w_done !== 1'b0 || w_mem_rd_en !== 1'b0 || w_mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: stall=%b done=%b rd_en=%b wr_en=%b, expected all 0", w_stall, w_done, w_mem_rd_en, w_mem_wr_en);
        end
        checks++;
        if (w_rd_data !== 32'h0 || w_illegal !== 1'b0 || t_misaligned !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: rd_data=%h illegal=%b trap_mis=%b, expected 0/0/0", w_rd_data, w_illegal, t_misaligned);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle();
        tb_addr = $urandom; tb_fun3 = 3'b010; tb_wr_data = $urandom;
        #1;
        checks++;
        if (w_mem_rd_en !== 1'b0 || w_mem_wr_en !== 1'b0 || w_done !== 1'b0 || w_rd_data !== 32'h0 || w_stall !== 1'b0) begin
            errors++;
            $display("FAIL idle: rd_en=%b wr_en=%b done=%b rd_data=%h stall=%b, expected 0/0/0/0/0", w_mem_rd_en, w_mem_wr_en, w_done, w_rd_data, w_stall);
        end
        @(negedge clk);
    endtask

    task automatic test_aligned();
        logic [31:0] wd;
        run_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        checks++;
        if (!obs_done || obs_cycles != 1 || !obs_stall_ok || obs_rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL aligned_lw: done=%b cycles=%0d stall_ok=%b rd=%h, expected 1/1/1/deadbeef", obs_done, obs_cycles, obs_stall_ok, obs_rd);
        end
        checks++;
        if (!seq_ok(1'b0, 3'b010, 32'h10, 32'h0)) begin
            errors++;
            $display("FAIL aligned_lw_seq: %0d accesses, expected 1 LW at 00000010", obs_addr_q.size());
        end
        run_access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
        checks++;
        if (!obs_done || obs_cycles != 1 || obs_rd !== 32'hFFFF_FFDE) begin
            errors++;
            $display("FAIL aligned_lb: done=%b cycles=%0d rd=%h, expected 1/1/ffffffde", obs_done, obs_cycles, obs_rd);
        end
        wd = $urandom;
        run_access(1'b0, 1'b1, 3'b001, 32'h20, wd, 1'b0);
        model_store(3'b001, 32'h20, wd);
        checks++;
        if (!obs_done || obs_cycles != 1 || obs_rd !== 32'h0 || !seq_ok(1'b1, 3'b001, 32'h20, wd)) begin
            errors++;
            $display("FAIL aligned_sh: done=%b cycles=%0d rd=%h accesses=%0d, expected 1/1/0/1", obs_done, obs_cycles, obs_rd, obs_addr_q.size());
        end
    endtask

    task automatic test_split_load();
        run_access(1'b1, 1'b0, 3'b001, 32'h3, 32'h0, 1'b0);
        checks++;
        if (!obs_done || obs_cycles != 3 || !obs_stall_ok || obs_mis || obs_rd !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL split_lh: done=%b cycles=%0d stall_ok=%b mis=%b rd=%h, expected 1/3/1/0/ffffff80", obs_done, obs_cycles, obs_stall_ok, obs_mis, obs_rd);
        end
        checks++;
        if (!seq_ok(1'b0, 3'b001, 32'h3, 32'h0)) begin
            errors++;
            $display("FAIL split_lh_seq: %0d accesses, expected 2 LBU at 00000003,00000004", obs_addr_q.size());
        end
        run_access(1'b1, 1'b0, 3'b101, 32'h3, 32'h0, 1'b0);
        checks++;
        if (!obs_done || obs_cycles != 3 || obs_rd !== 32'h0000_FF80) begin
            errors++;
            $display("FAIL split_lhu: done=%b cycles=%0d rd=%h, expected 1/3/0000ff80", obs_done, obs_cycles, obs_rd);
        end
        run_access(1'b1, 1'b0, 3'b010, 32'h11, 32'h0, 1'b0);
        checks++;
        if (!obs_done || obs_cycles != 5 || obs_rd !== model_load(3'b010, 32'h11) || !seq_ok(1'b0, 3'b010, 32'h11, 32'h0)) begin
            errors++;
            $display("FAIL split_lw: done=%b cycles=%0d rd=%h, expected 1/5/%h", obs_done, obs_cycles, obs_rd, model_load(3'b010, 32'h11));
        end
    endtask

    task automatic test_split_store();
        run_access(1'b0, 1'b1, 3'b010, 32'h5, 32'hA1B2_C3D4, 1'b0);
        model_store(3'b010, 32'h5, 32'hA1B2_C3D4);
        checks++;
        if (!obs_done || obs_cycles != 5 || !obs_stall_ok || obs_rd !== 32'h0) begin
            errors++;
            $display("FAIL split_sw: done=%b cycles=%0d stall_ok=%b rd=%h, expected 1/5/1/0", obs_done, obs_cycles, obs_stall_ok, obs_rd);
        end
        checks++;
        if (!seq_ok(1'b1, 3'b010, 32'h5, 32'hA1B2_C3D4)) begin
            errors++;
            $display("FAIL split_sw_seq: %0d accesses, expected SB d4/c3/b2/a1 at 5..8", obs_addr_q.size());
        end
        run_access(1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 1'b0);
        checks++;
        if (obs_rd[31:8] !== 24'hB2C3D4 || obs_rd !== model_load(3'b010, 32'h4)) begin
            errors++;
            $display("FAIL sw_readback_4: rd=%h, expected %h", obs_rd, model_load(3'b010, 32'h4));
        end
        run_access(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 1'b0);
        checks++;
        if (obs_rd[7:0] !== 8'hA1 || obs_rd !== model_load(3'b010, 32'h8)) begin
            errors++;
            $display("FAIL sw_readback_8: rd=%h, expected %h", obs_rd, model_load(3'b010, 32'h8));
        end
    endtask

    task automatic test_wrap();
        logic [31:0] wd;
        wd = $urandom;
        run_access(1'b0, 1'b1, 3'b001, 32'hFFFF_FFFF, wd, 1'b0);
        model_store(3'b001, 32'hFFFF_FFFF, wd);
        checks++;
        if (!obs_done || obs_cycles != 3 || !seq_ok(1'b1, 3'b001, 32'hFFFF_FFFF, wd)) begin
            errors++;
            $display("FAIL wrap_sh: done=%b cycles=%0d accesses=%0d, expected 1/3/2 at ffffffff,00000000", obs_done, obs_cycles, obs_addr_q.size());
        end
        run_access(1'b1, 1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, 1'b0);
        checks++;
        if (obs_rd !== model_load(3'b001, 32'hFFFF_FFFF) || !seq_ok(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0)) begin
            errors++;
            $display("FAIL wrap_lh: rd=%h, expected %h", obs_rd, model_load(3'b001, 32'hFFFF_FFFF));
        end
    endtask

    task automatic test_illegal();
        logic       ld_tab [3] = '{1'b1, 1'b1, 1'b0};
        logic       st_tab [3] = '{1'b0, 1'b1, 1'b1};
        logic [2:0] f3_tab [3] = '{3'b011, 3'b010, 3'b100};
        for (int i = 0; i < 3; i++) begin
            tb_load = ld_tab[i]; tb_store = st_tab[i]; tb_fun3 = f3_tab[i];
            tb_addr = 32'h10; tb_wr_data = $urandom;
            #1;
            checks++;
            if (w_illegal !== 1'b1 || w_done !== 1'b1 || w_rd_data !== 32'h0 || w_stall !== 1'b0 ||
                w_mem_rd_en !== 1'b0 || w_mem_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL illegal_%0d: illegal=%b done=%b rd=%h stall=%b rd_en=%b wr_en=%b, expected 1/1/0/0/0/0",
                         i, w_illegal, w_done, w_rd_data, w_stall, w_mem_rd_en, w_mem_wr_en);
            end
            @(negedge clk);
            tb_load = 1'b0; tb_store = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_trap();
        tb_load = 1'b1; tb_fun3 = 3'b010; tb_addr = 32'h2;
        #1;
        checks++;
        if (t_misaligned !== 1'b1 || t_mem_rd_en !== 1'b0 || t_mem_wr_en !== 1'b0 || t_stall !== 1'b0 || t_done !== 1'b0) begin
            errors++;
            $display("FAIL trap_lw: mis=%b rd_en=%b wr_en=%b stall=%b done=%b, expected 1/0/0/0/0",
                     t_misaligned, t_mem_rd_en, t_mem_wr_en, t_stall, t_done);
        end
        checks++;
        if (w_misaligned !== 1'b0 || w_stall !== 1'b1) begin
            errors++;
            $display("FAIL split_no_trap: mis=%b stall=%b, expected 0/1", w_misaligned, w_stall);
        end
        @(negedge clk);
        tb_load = 1'b0;
        repeat (5) @(negedge clk);
        tb_load = 1'b1; tb_fun3 = 3'b010; tb_addr = 32'h10; tb_wr_data = $urandom;
        #1;
        checks++;
        if (t_done !== 1'b1 || t_misaligned !== 1'b0 || t_illegal !== 1'b0 || t_rd_data !== model_load(3'b010, 32'h10) ||
            t_mem_addr !== 32'h10 || t_mem_fun3 !== 3'b010 || t_mem_wr_data !== tb_wr_data) begin
            errors++;
            $display("FAIL trap_aligned: done=%b mis=%b rd=%h addr=%h, expected 1/0/%h/00000010",
                     t_done, t_misaligned, t_rd_data, t_mem_addr, model_load(3'b010, 32'h10));
        end
        @(negedge clk);
        tb_load = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int it = 0; it < 60; it++) begin
            logic        ld;
            logic [2:0]  f3;
            logic [31:0] a, wd, exp_v;
            ld = ($urandom_range(0, 1) == 1);
            f3 = ld ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            a  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : 32'($urandom_range(0, 255));
            wd = $urandom;
            if (ld) exp_q.push_back(model_load(f3, a));
            run_access(ld, ~ld, f3, a, wd, 1'b1);
            if (!ld) model_store(f3, a, wd);
            checks++;
            if (!obs_done || obs_cycles != model_cycles(f3, a) || !obs_stall_ok) begin
                errors++;
                $display("FAIL rand_timing it=%0d f3=%0d a=%h: done=%b cycles=%0d stall_ok=%b, expected 1/%0d/1",
                         it, f3, a, obs_done, obs_cycles, obs_stall_ok, model_cycles(f3, a));
            end
            checks++;
            if (!seq_ok(~ld, f3, a, wd)) begin
                errors++;
                $display("FAIL rand_seq it=%0d f3=%0d a=%h: %0d accesses, expected %0d", it, f3, a, obs_addr_q.size(),
                         tb_is_mis(f3, a) ? tb_size(f3) : 1);
            end
            if (ld) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (obs_rd !== exp_v) begin
                    errors++;
                    $display("FAIL rand_load it=%0d f3=%0d a=%h: rd=%h, expected %h", it, f3, a, obs_rd, exp_v);
                end
            end
        end
    endtask

    task automatic test_reset_mid_split();
        tb_store = 1'b1; tb_fun3 = 3'b010; tb_addr = 32'h5; tb_wr_data = 32'h1122_3344;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0; tb_store = 1'b0;
        #1;
        checks++;
        if (w_stall !== 1'b0 || w_mem_wr_en !== 1'b0 || w_mem_rd_en !== 1'b0 || w_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: stall=%b wr_en=%b rd_en=%b done=%b, expected 0/0/0/0", w_stall, w_mem_wr_en, w_mem_rd_en, w_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_mem[5] = 8'h44;
        exp_mem[6] = 8'h33;
        checks++;
        if (mem[5] !== exp_mem[5] || mem[6] !== exp_mem[6] || mem[7] !== exp_mem[7] || mem[8] !== exp_mem[8]) begin
            errors++;
            $display("FAIL mid_reset_mem: bytes 5..8=%h %h %h %h, expected %h %h %h %h",
                     mem[5], mem[6], mem[7], mem[8], exp_mem[5], exp_mem[6], exp_mem[7], exp_mem[8]);
        end
        run_access(1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 1'b0);
        checks++;
        if (!obs_done || obs_cycles != 1 || obs_rd !== model_load(3'b010, 32'h4)) begin
            errors++;
            $display("FAIL post_reset_lw: done=%b cycles=%0d rd=%h, expected 1/1/%h", obs_done, obs_cycles, obs_rd, model_load(3'b010, 32'h4));
        end
    endtask

    task automatic test_final_memory();
        int bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== exp_mem[k]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL final_mem: %0d bytes differ, expected 0", bad);
        end
    endtask

    initial begin
        rst_n = 1'b0; tb_load = 1'b0; tb_store = 1'b0; tb_fun3 = 3'b000;
        tb_addr = 32'h0; tb_wr_data = 32'h0;
        for (int k = 0; k < 256; k++) init_mem[k] = 8'($urandom);
        init_mem[16] = 8'hEF; init_mem[17] = 8'hBE; init_mem[18] = 8'hAD; init_mem[19] = 8'hDE;
        init_mem[3]  = 8'h80; init_mem[4]  = 8'hFF;
        for (int k = 0; k < 256; k++) exp_mem[k] = init_mem[k];
        mem_load = 1'b1;
        @(negedge clk);
        mem_load = 1'b0;

        test_reset();
        test_idle();
        test_aligned();
        test_split_load();
        test_split_store();
        test_wrap();
        test_illegal();
        test_trap();
        test_random();
        test_reset_mid_split();
        test_final_memory();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
